move_scheduler: RTL and testbench

Frame-level controller that sequences every moving actor (pac-man plus ghosts) through the single shared wall-check/move unit once per game tick. It owns the authoritative block position of each mover. Each frame it issues one checker request per mover in fixed order and commits the returned block index. At frame end it reports completion and pac-man/ghost collision to the game logic and renderer.

---
 rtl/move_scheduler_if.sv | 14 +
 rtl/move_scheduler.sv | 157 +++++++++++++++
 tb/tb_move_scheduler.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/move_scheduler_if.sv
// Handshake between the frame scheduler and the shared wall-check/move unit.
// master = scheduler side, slave = checker side.
interface move_scheduler_if #(
  parameter int POS_W = 10
);
  logic             chk_start;
  logic [POS_W-1:0] chk_pos;
  logic [3:0]       chk_dir;
  logic             chk_done;
  logic [POS_W-1:0] chk_next;

  modport master (output chk_start, chk_pos, chk_dir, input  chk_done, chk_next);
  modport slave  (input  chk_start, chk_pos, chk_dir, output chk_done, chk_next);
endinterface

// File: rtl/move_scheduler.sv
// Per-tick sequencer: walks every mover through the shared checker in index order,
// commits returned blocks, and flags frame end, pac-man/ghost collision and errors.
module move_scheduler #(
  parameter int N_MOVERS    = 4,
  parameter int POS_W       = 10,
  parameter int TICK_CYCLES = 1666667,
  parameter int TIMEOUT     = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [N_MOVERS*POS_W-1:0] init_pos,
  input  logic [N_MOVERS*4-1:0]     dir_req,
  move_scheduler_if.master          chk_if,
  output logic [N_MOVERS*POS_W-1:0] pos,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      collide,
  output logic                      overrun,
  output logic                      err_timeout
);
  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int IDX_W = (N_MOVERS > 1) ? $clog2(N_MOVERS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_MOVERS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_WAIT_TICK, S_ISSUE, S_WAIT, S_FRAME_END} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            tick_q, tick_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [TMR_W-1:0]                tmr_q, tmr_d;
  logic [3:0]                      dir_q, dir_d;
  logic [N_MOVERS-1:0][POS_W-1:0]  pos_q, pos_d;
  logic                            busy_q, busy_d;
  logic                            overrun_q, overrun_d;
  logic                            err_q, err_d;

  logic [N_MOVERS-1:0][3:0]        dir_arr;
  logic [3:0]                      cur_dir;
  logic                            issue_ok;
  logic                            adv;
  logic [N_MOVERS-1:0]             hit;

  assign dir_arr  = dir_req;
  assign cur_dir  = dir_arr[idx_q];
  // Zero or conflicting direction bits mean "stand still": no checker slot is spent.
  assign issue_ok = (state_q == S_ISSUE) && $onehot(cur_dir);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmr_d     = tmr_q;
    dir_d     = dir_q;
    pos_d     = pos_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;
    err_d     = err_q;
    adv       = 1'b0;

    cnt_d  = cnt_q;
    if (enable) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    tick_d = enable && (cnt_q == CNT_LAST);

    // Ticks landing inside a frame are dropped, only remembered as overrun.
    if (tick_q && busy_q) overrun_d = 1'b1;

    case (state_q)
      S_WAIT_TICK: if (tick_q && enable) begin
        state_d = S_ISSUE;
        idx_d   = '0;
        busy_d  = 1'b1;
      end
      S_ISSUE: begin
        dir_d = cur_dir;
        if (issue_ok) begin
          tmr_d   = '0;
          state_d = S_WAIT;
        end else begin
          adv = 1'b1;
        end
      end
      S_WAIT: begin
        if (chk_if.chk_done) begin
          pos_d[idx_q] = chk_if.chk_next;
          adv          = 1'b1;
        end else if (tmr_q == TMR_LAST) begin
          err_d = 1'b1;
          adv   = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_FRAME_END: begin
        busy_d  = 1'b0;
        state_d = S_WAIT_TICK;
      end
      default: state_d = S_WAIT_TICK;
    endcase

    if (adv) begin
      if (idx_q == IDX_LAST) begin
        state_d = S_FRAME_END;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_ISSUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_WAIT_TICK;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      idx_q     <= '0;
      tmr_q     <= '0;
      dir_q     <= '0;
      pos_q     <= init_pos;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
    end
  end

  assign hit[0] = 1'b0;
  for (genvar i = 1; i < N_MOVERS; i++) begin : g_hit
    assign hit[i] = (pos_q[i] == pos_q[0]);
  end

  // The request bus reads zero whenever no mover is being serviced.
  assign chk_if.chk_start = issue_ok;
  assign chk_if.chk_pos   = (state_q == S_ISSUE || state_q == S_WAIT) ? pos_q[idx_q] : '0;
  assign chk_if.chk_dir   = (state_q == S_ISSUE) ? cur_dir :
                            (state_q == S_WAIT)  ? dir_q   : 4'b0000;

  assign pos         = pos_q;
  assign busy        = busy_q;
  assign frame_done  = (state_q == S_FRAME_END);
  assign collide     = frame_done && (|hit);
  assign overrun     = overrun_q;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_move_scheduler.sv
// Drives move_scheduler with a latency-programmable checker and compares every cycle
// against a frame-level schedule derived from the movement rules.
module tb_move_scheduler;
  localparam int N   = 4;
  localparam int PW  = 10;
  localparam int TC  = 8;
  localparam int TO  = 64;
  localparam int INF = 1 << 30;

  logic            clk = 1'b0;
  logic            reset, enable;
  logic [N*PW-1:0] init_pos;
  logic [N*4-1:0]  dir_req;
  logic [N*PW-1:0] pos;
  logic            busy, frame_done, collide, overrun, err_timeout;

  move_scheduler_if #(.POS_W(PW)) cif ();

  move_scheduler #(.N_MOVERS(N), .POS_W(PW), .TICK_CYCLES(TC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .init_pos(init_pos), .dir_req(dir_req),
    .chk_if(cif.master), .pos(pos), .busy(busy), .frame_done(frame_done),
    .collide(collide), .overrun(overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Scenario description; per-request settings are indexed by request order in a frame.
  logic [PW-1:0] ini[N];
  logic [3:0]    dr[N];
  int            lat[N];   // 0 = checker never answers
  int            step[N];
  bit            fxe[N];
  logic [PW-1:0] fxv[N];
  int            nfr;

  // Expected schedule, keyed by cycle since reset release.
  logic [PW-1:0] es_pos[int];
  logic [3:0]    es_dir[int];
  bit            fd_col[int];
  int            cm_mv[int];
  logic [PW-1:0] cm_val[int];
  int            blo[$], bhi[$];
  int            err_from, ovr_from, en_off, t_end;

  task automatic build_model();
    logic [PW-1:0] p[N];
    int tick, s, t, k;
    bit col;
    es_pos.delete(); es_dir.delete(); fd_col.delete(); cm_mv.delete(); cm_val.delete();
    blo.delete(); bhi.delete();
    for (int i = 0; i < N; i++) p[i] = ini[i];
    err_from = INF; ovr_from = INF; en_off = INF;
    tick = TC;
    for (int f = 0; f < nfr; f++) begin
      s = tick + 1; t = s; k = 0;
      if (f == nfr - 1) en_off = s + 1;
      for (int i = 0; i < N; i++) begin
        if ($countones(dr[i]) == 1) begin
          es_pos[t] = p[i]; es_dir[t] = dr[i];
          if (lat[k] == 0) begin
            if (err_from == INF) err_from = t + TO + 1;
            t += 1 + TO;
          end else begin
            p[i] = fxe[k] ? fxv[k] : p[i] + PW'(step[k]);
            cm_mv[t + lat[k] + 1]  = i;
            cm_val[t + lat[k] + 1] = p[i];
            t += 1 + lat[k];
          end
          k++;
        end else begin
          t += 1;
        end
      end
      col = 0;
      for (int i = 1; i < N; i++) if (p[i] == p[0]) col = 1;
      fd_col[t] = col;
      blo.push_back(s); bhi.push_back(t);
      for (int c = s; c <= t; c++)
        if (c % TC == 0 && c <= en_off && ovr_from == INF) ovr_from = c + 1;
      tick = (t / TC + 1) * TC;
      t_end = t;
    end
  endtask

  task automatic run_scn();
    logic [PW-1:0] epos[N];
    logic [N*PW-1:0] eflat;
    bit ebusy, pend, ecol;
    int k, done_c;
    logic [PW-1:0] pend_v;
    build_model();
    @(negedge clk);
    reset = 1; enable = 1; cif.chk_done = 0; cif.chk_next = '0;
    for (int i = 0; i < N; i++) begin
      init_pos[i*PW +: PW] = ini[i];
      dir_req[i*4 +: 4]    = dr[i];
      epos[i]              = ini[i];
    end
    repeat (2) @(negedge clk);
    reset = 0;
    k = 0; pend = 0; done_c = 0; pend_v = '0;
    for (int c = 0; c <= t_end + 20; c++) begin
      if (c > 0) @(negedge clk);
      if (c == en_off) enable = 0;
      if (cm_mv.exists(c)) epos[cm_mv[c]] = cm_val[c];
      ebusy = 0;
      foreach (blo[j]) if (c >= blo[j] && c <= bhi[j]) ebusy = 1;
      ecol = fd_col.exists(c) ? fd_col[c] : 1'b0;
      for (int i = 0; i < N; i++) eflat[i*PW +: PW] = epos[i];
      check("chk_start", cif.chk_start, es_pos.exists(c));
      if (es_pos.exists(c)) begin
        check("chk_pos", cif.chk_pos, es_pos[c]);
        check("chk_dir", cif.chk_dir, es_dir[c]);
      end
      if (c == 0) check("chk_pos_rst", cif.chk_pos, 0);
      check("busy", busy, ebusy);
      check("frame_done", frame_done, fd_col.exists(c));
      check("collide", collide, ecol);
      check("overrun", overrun, c >= ovr_from);
      check("err_timeout", err_timeout, c >= err_from);
      check("pos", pos, eflat);
      // checker model: answers relative to the block it is shown
      cif.chk_done = 0;
      if (pend && c == done_c) begin
        cif.chk_done = 1; cif.chk_next = pend_v; pend = 0;
      end
      if (cif.chk_start) begin
        if (lat[k] > 0) begin
          pend = 1; done_c = c + lat[k];
          pend_v = fxe[k] ? fxv[k] : cif.chk_pos + PW'(step[k]);
        end
        if (k < N - 1) k++;
      end
      if (frame_done) k = 0;
    end
    cif.chk_done = 0;
  endtask

  task automatic set_defaults();
    ini[0] = 10'h3C0; ini[1] = 10'h1EF; ini[2] = 10'h1F0; ini[3] = 10'h210;
    for (int i = 0; i < N; i++) begin
      dr[i] = 4'b0001; lat[i] = 3; step[i] = 1; fxe[i] = 0; fxv[i] = '0;
    end
    nfr = 2;
  endtask

  // Reset lands while a request is outstanding; a late answer must not be committed.
  task automatic rst_mid();
    logic [N*PW-1:0] ni;
    int w = 0;
    enable = 1;
    while (!cif.chk_start && w < 40) begin
      @(negedge clk); w++;
    end
    check("issue_wait", w < 40, 1);
    @(negedge clk);
    check("pre_rst_err", err_timeout, 1);
    for (int i = 0; i < N; i++) ni[i*PW +: PW] = PW'($urandom);
    reset = 1; init_pos = ni;
    @(negedge clk);
    cif.chk_done = 1; cif.chk_next = ~ni[PW-1:0];
    @(negedge clk);
    reset = 0;
    check("rst_pos", pos, ni);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    check("rst_err", err_timeout, 0);
    check("rst_start", cif.chk_start, 0);
    @(negedge clk);
    cif.chk_done = 0; enable = 0;
    check("rst_nocommit", pos, ni);
  endtask

  initial begin
    reset = 1; enable = 0; init_pos = '0; dir_req = '0;
    cif.chk_done = 0; cif.chk_next = '0;

    set_defaults(); run_scn();
    set_defaults(); dr[2] = 4'b0000; dr[3] = 4'b0101; run_scn();
    set_defaults(); dr[1] = 4'b0000; fxe[0] = 1; fxv[0] = 10'h1EF; run_scn();
    set_defaults(); lat[1] = 0; run_scn();
    rst_mid();

    for (int r = 0; r < 8; r++) begin
      ini[0] = PW'($urandom);
      for (int i = 1; i < N; i++)
        ini[i] = $urandom_range(0, 1) ? ini[0] + PW'($urandom_range(0, 3)) : PW'($urandom);
      for (int i = 0; i < N; i++) begin
        dr[i]   = $urandom_range(0, 3) != 0 ? 4'b0001 << $urandom_range(0, 3)
                                            : 4'($urandom_range(0, 15));
        lat[i]  = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 5);
        step[i] = $urandom_range(0, 3) == 3 ? 1023 : $urandom_range(0, 2);
        fxe[i]  = $urandom_range(0, 3) == 0;
        fxv[i]  = ini[$urandom_range(0, N - 1)];
      end
      nfr = $urandom_range(1, 3);
      run_scn();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
